// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic array
// and its result collector.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } coll_state_e;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int elem_w(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/systolic_result_collector.sv
// Collects N result rows from the systolic array and
// drains them element by element over valid/ready.
module systolic_result_collector
  import systolic_pkg::*;
#(
  parameter  int DATAWIDTH = 16,
  parameter  int N_SIZE    = 5,
  localparam int IDXW      = idx_w(N_SIZE),
  localparam int EW        = elem_w(DATAWIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [N_SIZE*EW-1:0] row_in,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EW-1:0]        out_data,
  output logic [IDXW-1:0]      out_row,
  output logic [IDXW-1:0]      out_col,
  output logic                 out_last,
  output logic                 overflow,
  input  logic                 clear_err
);

  localparam logic [IDXW-1:0] LAST_IDX =
    IDXW'(N_SIZE - 1);

  coll_state_e     state_q;
  coll_state_e     state_d;
  logic [IDXW-1:0] row_cnt_q;
  logic [IDXW-1:0] row_cnt_d;
  logic [IDXW-1:0] rd_row_q;
  logic [IDXW-1:0] rd_row_d;
  logic [IDXW-1:0] rd_col_q;
  logic [IDXW-1:0] rd_col_d;
  logic [EW-1:0]   mem_q [N_SIZE][N_SIZE];
  logic            ovf_q;

  logic            wr_en;
  logic [IDXW-1:0] wr_row;
  logic            draining;
  logic            hs;
  logic            at_last;
  logic            col_wrap;
  logic            drop;

  assign draining = (state_q == DRAIN);
  assign hs       = draining && out_ready;
  assign at_last  = (rd_row_q == LAST_IDX) &&
                    (rd_col_q == LAST_IDX);
  assign col_wrap = (rd_col_q == LAST_IDX) &&
                    (rd_row_q != LAST_IDX);
  assign drop     = valid_in && draining;

  // Next-state, capture write enable and drain pointer
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    rd_row_d  = rd_row_q;
    rd_col_d  = rd_col_q;
    wr_en     = 1'b0;
    wr_row    = row_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          wr_en  = 1'b1;
          wr_row = '0;
          if (N_SIZE == 1) begin
            state_d   = DRAIN;
            row_cnt_d = '0;
          end else begin
            state_d   = CAPTURE;
            row_cnt_d = IDXW'(1);
          end
        end
      end
      CAPTURE: begin
        if (valid_in) begin
          wr_en = 1'b1;
          if (row_cnt_q == LAST_IDX) begin
            state_d   = DRAIN;
            row_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (hs) begin
          unique case (1'b1)
            at_last: begin
              state_d  = IDLE;
              rd_row_d = '0;
              rd_col_d = '0;
            end
            col_wrap: begin
              rd_col_d = '0;
              rd_row_d = rd_row_q + 1'b1;
            end
            default: begin
              rd_col_d = rd_col_q + 1'b1;
            end
          endcase
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, row counter and read pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      rd_row_q  <= '0;
      rd_col_q  <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      rd_row_q  <= rd_row_d;
      rd_col_q  <= rd_col_d;
    end
  end

  // Row-wide write into the result buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N_SIZE; r++) begin
        for (int c = 0; c < N_SIZE; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int c = 0; c < N_SIZE; c++) begin
        mem_q[wr_row][c] <= row_in[c*EW +: EW];
      end
    end
  end

  // Sticky drop flag; a new drop beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (clear_err) begin
      ovf_q <= 1'b0;
    end
  end

  // Outputs come straight from flops (state, pointer,
  // buffer); data is zeroed outside DRAIN
  assign in_ready  = !draining;
  assign out_valid = draining;
  assign out_row   = rd_row_q;
  assign out_col   = rd_col_q;
  assign out_last  = draining && at_last;
  assign out_data  = draining ?
                     mem_q[rd_row_q][rd_col_q] : '0;
  assign overflow  = ovf_q;

endmodule
